// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for a small MIPS subset: fetches an instruction,
// decodes it, and steps the datapath through EXEC / MEM / WB with single-cycle strobes.
module datapath_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        imem_ack,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_q,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [31:0] pc_data_in,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  output logic [4:0]  write_reg,
  output logic        write,
  output logic [31:0] alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic        mem_to_reg,
  output logic        dmu_wen,
  output logic        instr_done,
  output logic        illegal,
  output logic [2:0]  dbg_state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic        r_illegal;
  logic        r_fresh;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_is_r;
  logic        w_is_j;
  logic        w_is_beq;
  logic        w_is_addi;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_funct_ok;
  logic [2:0]  w_r_alu;
  logic [2:0]  w_alu;
  logic        w_legal;
  logic        w_take_fetch;

  assign w_opcode  = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_is_r    = (w_opcode == OP_RTYPE);
  assign w_is_j    = (w_opcode == OP_J);
  assign w_is_beq  = (w_opcode == OP_BEQ);
  assign w_is_addi = (w_opcode == OP_ADDI);
  assign w_is_lw   = (w_opcode == OP_LW);
  assign w_is_sw   = (w_opcode == OP_SW);

  always_comb begin
    w_funct_ok = 1'b1;
    w_r_alu    = 3'd0;
    case (w_funct)
      FN_ADD:  w_r_alu = 3'd0;
      FN_SUB:  w_r_alu = 3'd1;
      FN_AND:  w_r_alu = 3'd2;
      FN_OR:   w_r_alu = 3'd3;
      FN_SLT:  w_r_alu = 3'd4;
      default: w_funct_ok = 1'b0;
    endcase
  end

  assign w_legal = (w_is_r && w_funct_ok) || w_is_j || w_is_beq ||
                   w_is_addi || w_is_lw || w_is_sw;
  assign w_alu   = w_is_r ? w_r_alu : (w_is_beq ? 3'd1 : 3'd0);

  // r_fresh blanks the fetch request for the first cycle after clr.
  assign w_take_fetch = (r_state == S_FETCH) && run && !r_fresh && imem_ack;

  // Register-file addressing and immediate are pure IR decodes.
  assign read_reg_1  = r_ir[25:21];
  assign read_reg_2  = r_ir[20:16];
  assign write_reg   = w_is_r ? r_ir[15:11] : r_ir[20:16];
  assign imm_ext     = {{16{r_ir[15]}}, r_ir[15:0]};
  assign alu_op      = {29'd0, w_alu};
  assign alu_src_imm = w_is_addi || w_is_lw || w_is_sw;
  assign mem_to_reg  = w_is_lw;
  assign illegal     = r_illegal;
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_FETCH;
      r_ir      <= 32'd0;
      r_illegal <= 1'b0;
      r_fresh   <= 1'b1;
    end else begin
      r_state <= w_next;
      r_fresh <= 1'b0;
      if (w_take_fetch) r_ir <= instr_in;
      if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_take_fetch) w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_ERROR;
      S_EXEC: begin
        if (w_is_r || w_is_addi)    w_next = S_WB;
        else if (w_is_lw || w_is_sw) w_next = S_MEM;
        else                         w_next = S_FETCH;
      end
      S_MEM:    w_next = w_is_lw ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_FETCH;
    endcase
  end

  // Strobes are decoded from state and IR; clr suppresses them immediately.
  always_comb begin
    imem_req   = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    pc_data_in = 32'd0;
    write      = 1'b0;
    dmu_wen    = 1'b0;
    instr_done = 1'b0;
    if (!clr) begin
      case (r_state)
        S_FETCH: begin
          imem_req = run && !r_fresh;
          pc_inc   = w_take_fetch;
        end
        S_EXEC: begin
          if (w_is_j) begin
            pc_ld      = 1'b1;
            pc_data_in = {pc_q[31:26], r_ir[25:0]};
          end else if (w_is_beq && alu_zero) begin
            pc_ld      = 1'b1;
            pc_data_in = pc_q + imm_ext;
          end
          instr_done = w_is_j || w_is_beq;
        end
        S_MEM: begin
          dmu_wen    = w_is_sw;
          instr_done = w_is_sw;
        end
        S_WB: begin
          write      = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
